// File: rtl/alu_exe_unit_pkg.sv
// -----------------------------------------------------------------------------
// alu_exe_unit_pkg
// Shared definitions for the ALU execute unit:
//   - default widths (data, pc, RRF tag, opcode)
//   - ALU opcode encoding
//   - MUL sequencing FSM state encoding
// -----------------------------------------------------------------------------
package alu_exe_unit_pkg;

  localparam int DATA_LEN     = 32;
  localparam int ADDR_LEN     = 32;
  localparam int RRF_SEL      = 6;
  localparam int ALU_OP_WIDTH = 4;

  // Codes 11..15 are unassigned and produce a zero result in a single cycle.
  typedef enum logic [ALU_OP_WIDTH-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_exe_unit_if.sv
// -----------------------------------------------------------------------------
// alu_exe_unit_if
// ALU issue / result bus between the select-wakeup stage (master) and the
// ALU execute unit (slave). Signal suffixes are from the execute unit's view.
//   issue side : issue_i, op_1_i, op_2_i, pc_i, imm_i, src_a_sel_i,
//                src_b_sel_i, rrf_tag_i, dst_val_i, alu_op_i, kill_i
//   back-press : busy_o
//   result side: result_o, result_tag_o, result_valid_o, fwd_valid_o, rrf_we_o
// -----------------------------------------------------------------------------
interface alu_exe_unit_if
  import alu_exe_unit_pkg::*;
#(
  parameter int DATA_LEN_P     = DATA_LEN,
  parameter int ADDR_LEN_P     = ADDR_LEN,
  parameter int RRF_SEL_P      = RRF_SEL,
  parameter int ALU_OP_WIDTH_P = ALU_OP_WIDTH
);

  logic                      issue_i;
  logic [DATA_LEN_P-1:0]     op_1_i;
  logic [DATA_LEN_P-1:0]     op_2_i;
  logic [ADDR_LEN_P-1:0]     pc_i;
  logic [DATA_LEN_P-1:0]     imm_i;
  logic                      src_a_sel_i;
  logic                      src_b_sel_i;
  logic [RRF_SEL_P-1:0]      rrf_tag_i;
  logic                      dst_val_i;
  logic [ALU_OP_WIDTH_P-1:0] alu_op_i;
  logic                      kill_i;

  logic                      busy_o;
  logic [DATA_LEN_P-1:0]     result_o;
  logic [RRF_SEL_P-1:0]      result_tag_o;
  logic                      result_valid_o;
  logic                      fwd_valid_o;
  logic                      rrf_we_o;

  modport master (
    output issue_i, op_1_i, op_2_i, pc_i, imm_i, src_a_sel_i, src_b_sel_i,
           rrf_tag_i, dst_val_i, alu_op_i, kill_i,
    input  busy_o, result_o, result_tag_o, result_valid_o, fwd_valid_o, rrf_we_o
  );

  modport slave (
    input  issue_i, op_1_i, op_2_i, pc_i, imm_i, src_a_sel_i, src_b_sel_i,
           rrf_tag_i, dst_val_i, alu_op_i, kill_i,
    output busy_o, result_o, result_tag_o, result_valid_o, fwd_valid_o, rrf_we_o
  );

endinterface

// File: rtl/alu_exe_unit_core.sv
// -----------------------------------------------------------------------------
// alu_exe_unit_core
// Purely combinational single-cycle ALU.
//   alu_op_i : opcode (alu_op_e encoding)
//   a_i, b_i : operands after the source mux
//   result_o : single-cycle result; MUL and unassigned codes return 0 (MUL is
//              sequenced by the parent from its holding registers)
// -----------------------------------------------------------------------------
module alu_exe_unit_core
  import alu_exe_unit_pkg::*;
#(
  parameter int DATA_LEN_P     = DATA_LEN,
  parameter int ALU_OP_WIDTH_P = ALU_OP_WIDTH
) (
  input  logic [ALU_OP_WIDTH_P-1:0] alu_op_i,
  input  logic [DATA_LEN_P-1:0]     a_i,
  input  logic [DATA_LEN_P-1:0]     b_i,
  output logic [DATA_LEN_P-1:0]     result_o
);

  localparam int SHW = $clog2(DATA_LEN_P);

  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  // Only the low log2(DATA_LEN) bits of B select the shift distance.
  assign shamt = b_i[SHW-1:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  always_comb begin
    // NOTE: every path must assign result_o, so a default comes first; a
    // combinational block that leaves an output unassigned infers a latch.
    result_o = '0;
    case (alu_op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_SLL:  result_o = a_i << shamt;
      OP_SLT:  result_o = {{(DATA_LEN_P-1){1'b0}}, lt_s};
      OP_SLTU: result_o = {{(DATA_LEN_P-1){1'b0}}, lt_u};
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SRL:  result_o = a_i >> shamt;
      OP_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      OP_OR:   result_o = a_i | b_i;
      OP_AND:  result_o = a_i & b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_exe_unit.sv
// -----------------------------------------------------------------------------
// alu_exe_unit
// Execute-side consumer of the ALU issue interface. Accepts one entry per
// cycle, produces a registered result broadcast as ROB finish
// (result_valid_o), wakeup/forwarding (fwd_valid_o) and RRF write (rrf_we_o).
// Single-cycle ops complete the cycle after issue; MUL takes MUL_LAT cycles
// and holds busy_o high while in flight.
//   clk_i, reset_i : clock, synchronous active-high reset
//   bus            : alu_exe_unit_if slave (issue inputs, busy, results)
// -----------------------------------------------------------------------------
module alu_exe_unit
  import alu_exe_unit_pkg::*;
#(
  parameter int DATA_LEN_P     = DATA_LEN,
  parameter int ADDR_LEN_P     = ADDR_LEN,
  parameter int RRF_SEL_P      = RRF_SEL,
  parameter int ALU_OP_WIDTH_P = ALU_OP_WIDTH,
  parameter int MUL_LAT        = 3
) (
  input  logic           clk_i,
  input  logic           reset_i,
  alu_exe_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_LEN_P-1:0]  mul_a_q, mul_a_d;
  logic [DATA_LEN_P-1:0]  mul_b_q, mul_b_d;
  logic [RRF_SEL_P-1:0]   mul_tag_q, mul_tag_d;
  logic                   mul_dst_q, mul_dst_d;

  logic [DATA_LEN_P-1:0]  result_q, result_d;
  logic [RRF_SEL_P-1:0]   tag_q, tag_d;
  logic                   valid_q, valid_d;
  logic                   fwd_q, fwd_d;

  logic [DATA_LEN_P-1:0]  src_a;
  logic [DATA_LEN_P-1:0]  src_b;
  logic [DATA_LEN_P-1:0]  core_result;
  logic [DATA_LEN_P-1:0]  mul_prod;

  assign src_a    = bus.src_a_sel_i ? DATA_LEN_P'(bus.pc_i) : bus.op_1_i;
  assign src_b    = bus.src_b_sel_i ? bus.imm_i : bus.op_2_i;
  // Truncating to DATA_LEN keeps the low half of the product (wraps).
  assign mul_prod = mul_a_q * mul_b_q;

  alu_exe_unit_core #(
    .DATA_LEN_P     (DATA_LEN_P),
    .ALU_OP_WIDTH_P (ALU_OP_WIDTH_P)
  ) u_core (
    .alu_op_i (bus.alu_op_i),
    .a_i      (src_a),
    .b_i      (src_b),
    .result_o (core_result)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_tag_d = mul_tag_q;
    mul_dst_d = mul_dst_q;
    result_d  = result_q;   // result/tag hold when no completion
    tag_d     = tag_q;
    valid_d   = 1'b0;
    fwd_d     = 1'b0;

    if (bus.kill_i) begin
      // Flush drops any concurrent issue and discards an in-flight MUL,
      // including one that would have completed at this edge.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // In IDLE busy_o is low, so issue_i alone means acceptance.
          if (bus.issue_i) begin
            if (bus.alu_op_i == OP_MUL) begin
              state_d   = ST_MUL;
              cnt_d     = CNT_W'(MUL_LAT - 1);
              mul_a_d   = src_a;
              mul_b_d   = src_b;
              mul_tag_d = bus.rrf_tag_i;
              mul_dst_d = bus.dst_val_i;
            end else begin
              result_d = core_result;
              tag_d    = bus.rrf_tag_i;
              valid_d  = 1'b1;
              fwd_d    = bus.dst_val_i;
            end
          end
        end
        ST_MUL: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d  = ST_IDLE;
            result_d = mul_prod;
            tag_d    = mul_tag_q;
            valid_d  = 1'b1;
            fwd_d    = mul_dst_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset_i) begin
      // NOTE: the MUL holding registers are ordinary flops, not a memory
      // array, so clearing them on reset costs nothing and keeps them defined.
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_tag_q <= '0;
      mul_dst_q <= 1'b0;
      result_q  <= '0;
      tag_q     <= '0;
      valid_q   <= 1'b0;
      fwd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_tag_q <= mul_tag_d;
      mul_dst_q <= mul_dst_d;
      result_q  <= result_d;
      tag_q     <= tag_d;
      valid_q   <= valid_d;
      fwd_q     <= fwd_d;
    end
  end

  assign bus.busy_o         = (state_q == ST_MUL);
  assign bus.result_o       = result_q;
  assign bus.result_tag_o   = tag_q;
  assign bus.result_valid_o = valid_q;
  assign bus.fwd_valid_o    = fwd_q;
  assign bus.rrf_we_o       = fwd_q;

endmodule

// File: tb/tb_alu_exe_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exe_unit
// Directed self-checking bench for alu_exe_unit (MUL_LAT = 3). Inputs change
// 1 ns after a rising edge; outputs are sampled at that same point, so each
// sample reflects the edge just taken.
// -----------------------------------------------------------------------------
module tb_alu_exe_unit;
  import alu_exe_unit_pkg::*;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_exe_unit_if bus ();

  alu_exe_unit #(.MUL_LAT(3)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_i     = 1'b0;
    bus.kill_i      = 1'b0;
    bus.op_1_i      = '0;
    bus.op_2_i      = '0;
    bus.pc_i        = '0;
    bus.imm_i       = '0;
    bus.src_a_sel_i = 1'b0;
    bus.src_b_sel_i = 1'b0;
    bus.rrf_tag_i   = '0;
    bus.dst_val_i   = 1'b0;
    bus.alu_op_i    = '0;
  endtask

  // Register-register issue (A=op_1, B=op_2).
  task automatic issue_rr(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] tag,
                          input logic dst);
    bus.issue_i     = 1'b1;
    bus.alu_op_i    = op;
    bus.op_1_i      = a;
    bus.op_2_i      = b;
    bus.src_a_sel_i = 1'b0;
    bus.src_b_sel_i = 1'b0;
    bus.rrf_tag_i   = tag;
    bus.dst_val_i   = dst;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.result_o !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result_o); end
    checks++; if (bus.result_tag_o !== 6'h0) begin errors++; $display("FAIL reset_tag got=%h exp=0", bus.result_tag_o); end
    checks++; if ({bus.result_valid_o, bus.fwd_valid_o, bus.rrf_we_o, bus.busy_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {bus.result_valid_o, bus.fwd_valid_o, bus.rrf_we_o, bus.busy_o}); end
    rst = 1'b0;
    // ADD A=5, B=imm 7 (op_2 carries a decoy value)
    issue_rr(OP_ADD, 32'd5, 32'd99, 6'd3, 1'b1);
    bus.imm_i       = 32'd7;
    bus.src_b_sel_i = 1'b1;
    tick();
    idle();
    checks++; if (bus.result_o !== 32'd12) begin errors++; $display("FAIL add_imm_result got=%h exp=%h", bus.result_o, 32'd12); end
    checks++; if (bus.result_tag_o !== 6'd3) begin errors++; $display("FAIL add_imm_tag got=%h exp=3", bus.result_tag_o); end
    checks++; if ({bus.result_valid_o, bus.fwd_valid_o, bus.rrf_we_o} !== 3'b111) begin
      errors++; $display("FAIL add_imm_valids got=%b exp=111", {bus.result_valid_o, bus.fwd_valid_o, bus.rrf_we_o}); end
    tick();
    checks++; if ({bus.result_valid_o, bus.fwd_valid_o, bus.rrf_we_o} !== 3'b000) begin
      errors++; $display("FAIL add_pulse_end got=%b exp=000", {bus.result_valid_o, bus.fwd_valid_o, bus.rrf_we_o}); end
    checks++; if (bus.result_o !== 32'd12) begin errors++; $display("FAIL result_hold got=%h exp=%h", bus.result_o, 32'd12); end
  endtask

  task automatic test_pc_src();
    issue_rr(OP_ADD, 32'd77, 32'd0, 6'd8, 1'b1);
    bus.pc_i        = 32'h0000_1000;
    bus.imm_i       = 32'd4;
    bus.src_a_sel_i = 1'b1;
    bus.src_b_sel_i = 1'b1;
    tick();
    idle();
    checks++; if (bus.result_o !== 32'h0000_1004) begin errors++; $display("FAIL pc_plus_imm got=%h exp=00001004", bus.result_o); end
    tick();
  endtask

  task automatic test_ops();
    logic [3:0]  ops  [10] = '{OP_SRA, OP_SLT, OP_SLTU, OP_SUB, OP_SLL,
                              OP_SRL, OP_XOR, OP_OR, OP_AND, 4'd12};
    logic [31:0] va   [10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1,
                              32'h8000_0000, 32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0, 32'h1234_5678};
    logic [31:0] vb   [10] = '{32'h21, 32'h1, 32'h1, 32'h1, 32'h24,
                              32'h1F, 32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00, 32'h1};
    logic [31:0] vexp [10] = '{32'hC000_0000, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h10,
                              32'h1, 32'h0000_0FF0, 32'h0000_FFF0, 32'h0000_F000, 32'h0};
    for (int i = 0; i < 10; i++) begin
      issue_rr(ops[i], va[i], vb[i], 6'(i + 16), 1'b1);
      tick();
      checks++; if (bus.result_o !== vexp[i] || bus.result_valid_o !== 1'b1) begin
        errors++; $display("FAIL op%0d_result got=%h v=%b exp=%h v=1", ops[i], bus.result_o, bus.result_valid_o, vexp[i]); end
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      issue_rr(OP_ADD, 32'd10, 32'(i), 6'(i), 1'b1);
      tick();
      checks++; if (bus.result_valid_o !== 1'b1 || bus.result_tag_o !== 6'(i) ||
                    bus.result_o !== 32'(10 + i) || bus.busy_o !== 1'b0) begin
        errors++; $display("FAIL b2b_%0d got v=%b tag=%0d res=%0d busy=%b exp v=1 tag=%0d res=%0d busy=0",
                           i, bus.result_valid_o, bus.result_tag_o, bus.result_o, bus.busy_o, i, 10 + i); end
    end
    idle();
    tick();
    checks++; if (bus.result_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_end got v=%b exp 0", bus.result_valid_o); end
  endtask

  task automatic test_mul();
    // Cycle N: MUL wraps to zero.
    issue_rr(OP_MUL, 32'h0001_0000, 32'h0001_0000, 6'd7, 1'b1);
    tick();
    // Cycle N+1: busy, ADD issue must be ignored.
    checks++; if (bus.busy_o !== 1'b1 || bus.result_valid_o !== 1'b0) begin
      errors++; $display("FAIL mul_n1 got busy=%b v=%b exp busy=1 v=0", bus.busy_o, bus.result_valid_o); end
    issue_rr(OP_ADD, 32'd1, 32'd1, 6'd9, 1'b1);
    tick();
    // Cycle N+2: still busy, ignored ADD must not have completed.
    checks++; if (bus.busy_o !== 1'b1 || bus.result_valid_o !== 1'b0) begin
      errors++; $display("FAIL mul_n2 got busy=%b v=%b exp busy=1 v=0", bus.busy_o, bus.result_valid_o); end
    issue_rr(OP_ADD, 32'd1, 32'd1, 6'd9, 1'b1);
    tick();
    // Cycle N+3: completion, busy released; accept a new ADD here.
    checks++; if (bus.result_valid_o !== 1'b1 || bus.result_o !== 32'h0 || bus.result_tag_o !== 6'd7 ||
                  bus.fwd_valid_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL mul_done got v=%b res=%h tag=%0d fwd=%b busy=%b exp v=1 res=0 tag=7 fwd=1 busy=0",
                         bus.result_valid_o, bus.result_o, bus.result_tag_o, bus.fwd_valid_o, bus.busy_o); end
    issue_rr(OP_ADD, 32'd1, 32'd2, 6'd4, 1'b1);
    tick();
    checks++; if (bus.result_valid_o !== 1'b1 || bus.result_o !== 32'd3 || bus.result_tag_o !== 6'd4) begin
      errors++; $display("FAIL issue_after_mul got v=%b res=%h tag=%0d exp v=1 res=3 tag=4",
                         bus.result_valid_o, bus.result_o, bus.result_tag_o); end
    // Non-wrapping product from the register/imm path.
    issue_rr(OP_MUL, 32'd1234, 32'd0, 6'd11, 1'b1);
    bus.imm_i       = 32'd5678;
    bus.src_b_sel_i = 1'b1;
    tick();
    idle();
    tick();
    tick();
    checks++; if (bus.result_valid_o !== 1'b1 || bus.result_o !== 32'd7006652 || bus.result_tag_o !== 6'd11) begin
      errors++; $display("FAIL mul_value got v=%b res=%0d tag=%0d exp v=1 res=7006652 tag=11",
                         bus.result_valid_o, bus.result_o, bus.result_tag_o); end
    tick();
  endtask

  task automatic test_kill();
    // Kill in N+1 of a MUL.
    issue_rr(OP_MUL, 32'd3, 32'd4, 6'd5, 1'b1);
    tick();
    idle();
    bus.kill_i = 1'b1;
    tick();
    bus.kill_i = 1'b0;
    checks++; if (bus.busy_o !== 1'b0 || bus.result_valid_o !== 1'b0) begin
      errors++; $display("FAIL kill_mul_n2 got busy=%b v=%b exp 0 0", bus.busy_o, bus.result_valid_o); end
    tick();
    checks++; if (bus.result_valid_o !== 1'b0) begin errors++; $display("FAIL kill_mul_late got v=%b exp 0", bus.result_valid_o); end
    // Kill in the completion cycle (N+2).
    issue_rr(OP_MUL, 32'd3, 32'd4, 6'd6, 1'b1);
    tick();
    idle();
    tick();
    bus.kill_i = 1'b1;
    tick();
    bus.kill_i = 1'b0;
    checks++; if (bus.result_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL kill_at_done got v=%b busy=%b exp 0 0", bus.result_valid_o, bus.busy_o); end
    // Kill concurrent with ADD issue.
    issue_rr(OP_ADD, 32'd8, 32'd8, 6'd2, 1'b1);
    bus.kill_i = 1'b1;
    tick();
    idle();
    checks++; if (bus.result_valid_o !== 1'b0 || bus.fwd_valid_o !== 1'b0) begin
      errors++; $display("FAIL kill_with_issue got v=%b fwd=%b exp 0 0", bus.result_valid_o, bus.fwd_valid_o); end
    tick();
    checks++; if (bus.result_valid_o !== 1'b0) begin errors++; $display("FAIL kill_issue_late got v=%b exp 0", bus.result_valid_o); end
  endtask

  task automatic test_no_dst();
    issue_rr(OP_XOR, 32'h0000_00FF, 32'h0000_000F, 6'd12, 1'b0);
    tick();
    idle();
    checks++; if ({bus.result_valid_o, bus.fwd_valid_o, bus.rrf_we_o} !== 3'b100 ||
                  bus.result_tag_o !== 6'd12 || bus.result_o !== 32'h0000_00F0) begin
      errors++; $display("FAIL no_dst got vfw=%b tag=%0d res=%h exp vfw=100 tag=12 res=000000f0",
                         {bus.result_valid_o, bus.fwd_valid_o, bus.rrf_we_o}, bus.result_tag_o, bus.result_o); end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    issue_rr(OP_MUL, 32'd6, 32'd7, 6'd13, 1'b1);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.busy_o !== 1'b0 || bus.result_valid_o !== 1'b0 || bus.result_o !== 32'h0 ||
                  bus.result_tag_o !== 6'h0) begin
      errors++; $display("FAIL reset_mid_mul got busy=%b v=%b res=%h tag=%0d exp all 0",
                         bus.busy_o, bus.result_valid_o, bus.result_o, bus.result_tag_o); end
    tick();
    checks++; if (bus.result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_mid_mul_late got v=%b exp 0", bus.result_valid_o); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_pc_src();
    test_ops();
    test_back_to_back();
    test_mul();
    test_kill();
    test_no_dst();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
